controle_rodada: RTL and testbench
==================================

// Module: controle_rodada
// PURPOSE
//  Round referee for the two-player LED ping-pong game. Moves a ball along WIDTH
//  positions and judges hits, misses and fouls from the players' button pulses.
//  Produces the p1vic/p2vic round-win levels consumed by the scoring stage, and
//  freezes when that stage raises game_over.
// PARAMETERS
//  WIDTH         8         ball positions; position 0 = P2 end, WIDTH-1 = P1 end
//  TICK_DIV      25000000  clock cycles per ball step at speed level 0 (>=8)
//  HOLD_TICKS    3         base-period ticks p1vic/p2vic stay high after a point
//  SPEEDUP_HITS  4         successful hits per speed level increase
// PORTS
//  clock      in   1              system clock, all logic on rising edge
//  reset      in   1              synchronous, active-low; 0 at a rising edge resets
//  b1         in   1              P1 button, single-cycle pulse (already debounced/edge-detected)
//  b2         in   1              P2 button, single-cycle pulse
//  game_over  in   1              from scoring stage; 1 = match finished
//  p1vic      out  1              level, P1 won the current round
//  p2vic      out  1              level, P2 won the current round
//  ball_pos   out  $clog2(WIDTH)  current ball index
//  ball_led   out  WIDTH          one-hot of ball_pos; all zero in STOP
//  state_o    out  3              encoded FSM state (debug)
// BEHAVIOUR
//  Reset (reset==0): state IDLE, server=P1, ball_pos=WIDTH-1, ball_led=1<<(WIDTH-1),
//   p1vic=p2vic=0, speed level=0, hit count=0, divider=0.
//  Divider: counts 0..P-1, P = TICK_DIV>>level, level 0..3 saturating; tick = 1-cycle
//   strobe when count==P-1. Divider clears on serve, on hit, on entering POINT.
//  States: IDLE, MOVE_P1 (toward WIDTH-1), MOVE_P2 (toward 0), POINT, STOP.
//  IDLE: ball parked at server end. Server's pulse -> MOVE toward the opponent next
//   cycle; level=0, hits=0. Non-server pulse ignored.
//  MOVE: on tick, if ball not at receiver end, step one position (registered, visible
//   the cycle after tick).
//   Hit: receiver's pulse while ball_pos == receiver end -> direction reversed, hits+1,
//    level+1 when hits reaches a multiple of SPEEDUP_HITS (saturate 3). The ball leaves
//    on the next tick.
//   Miss: tick while ball at receiver end with no hit -> POINT, opponent of receiver wins.
//   Foul: any pulse from the non-receiver, or a receiver pulse with ball not at its end
//    -> POINT, other player wins.
//   b1 & b2 in the same cycle: both ignored in every state (no hit, no foul, no serve).
//   Hit and tick in the same cycle: hit wins (no miss).
//  POINT: winner's vic=1, other=0, held for HOLD_TICKS ticks at TICK_DIV (level ignored).
//   Then vic->0, server=loser, ball parked at loser's end, state IDLE.
//  game_over==1 sampled in any state -> STOP next cycle; p1vic=p2vic=0, ball_led=0,
//   buttons ignored. Leave STOP only by reset.
//  Reset mid-round or mid-POINT: all of the above reset values, next cycle, no vic glitch.
//  Outputs registered. At most one of p1vic/p2vic high. Never both.
// TESTING (WIDTH=8, TICK_DIV=8, HOLD_TICKS=2, SPEEDUP_HITS=2)
//  1 reset=0 two cycles, release -> ball_pos=7, ball_led=8'h80, state IDLE, vics 0.
//  2 b1 pulse in IDLE -> ball_pos 6,5,...,0 at 8-cycle steps; no b2 -> p1vic=1 for 16
//    cycles, then IDLE with ball_pos=0, server P2.
//  3 Rally: b2 while pos=0, b1 while pos=7, b2 again -> after the 2nd hit the step is
//    4 cycles; after the 4th hit the step is 2 cycles.
//  4 b2 pulse while ball moving to P1 at pos 4 -> foul, p1vic=1. b1 at pos 3 moving
//    toward P1 -> p2vic=1.
//  5 b1&b2 same cycle at pos 7 receiver P1 -> ignored, miss on next tick -> p2vic=1.
//  6 game_over=1 during MOVE -> STOP, ball_led=0, vics 0, buttons ignored. reset=0 -> IDLE.

Source files
------------

// File: rtl/controle_rodada.sv
// rtl/controle_rodada.sv - round referee: ball motion, hit/miss/foul judging, point hold
module controle_rodada #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 25000000,
  parameter int HOLD_TICKS   = 3,
  parameter int SPEEDUP_HITS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     b1,
  input  logic                     b2,
  input  logic                     game_over,
  output logic                     p1vic,
  output logic                     p2vic,
  output logic [$clog2(WIDTH)-1:0] ball_pos,
  output logic [WIDTH-1:0]         ball_led,
  output logic [2:0]               state_o
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int SW = $clog2(SPEEDUP_HITS + 1);
  localparam logic [PW-1:0] END_P1 = PW'(WIDTH - 1);
  localparam logic [PW-1:0] END_P2 = '0;
  localparam logic [CW-1:0] TD     = CW'(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_P1 = 3'd1,
    MOVE_P2 = 3'd2,
    POINT   = 3'd3,
    STOP    = 3'd4
  } state_t;

  state_t        state;
  logic          server_p2;
  logic [1:0]    level;
  logic [SW-1:0] hits;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;

  logic [CW-1:0] period;
  logic          tick;
  logic          only1, only2;
  logic          recv_p1, at_end, recv_press, other_press;

  function automatic logic [WIDTH-1:0] onehot(input logic [PW-1:0] p);
    return WIDTH'(1) << p;
  endfunction

  // The point hold always runs at the base rate, whatever the rally speed was.
  always_comb begin
    period      = (state == POINT) ? TD : (TD >> level);
    tick        = (cnt == period - CW'(1));
    only1       = b1 & ~b2;
    only2       = b2 & ~b1;
    recv_p1     = (state == MOVE_P1);
    at_end      = recv_p1 ? (ball_pos == END_P1) : (ball_pos == END_P2);
    recv_press  = recv_p1 ? only1 : only2;
    other_press = recv_p1 ? only2 : only1;
  end

  assign state_o = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      server_p2 <= 1'b0;
      ball_pos  <= END_P1;
      ball_led  <= onehot(END_P1);
      p1vic     <= 1'b0;
      p2vic     <= 1'b0;
      level     <= '0;
      hits      <= '0;
      cnt       <= '0;
      hold      <= '0;
    end else if (game_over) begin
      state    <= STOP;
      p1vic    <= 1'b0;
      p2vic    <= 1'b0;
      ball_led <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (server_p2 ? only2 : only1) begin
            state <= server_p2 ? MOVE_P1 : MOVE_P2;
            level <= '0;
            hits  <= '0;
          end
        end
        MOVE_P1, MOVE_P2: begin
          if (recv_press && at_end) begin
            state <= recv_p1 ? MOVE_P2 : MOVE_P1;
            cnt   <= '0;
            if (hits == SW'(SPEEDUP_HITS - 1)) begin
              hits <= '0;
              if (level != 2'd3) level <= level + 2'd1;
            end else begin
              hits <= hits + SW'(1);
            end
          end else if (recv_press || other_press) begin
            // Foul: whoever pressed loses the point.
            state <= POINT;
            cnt   <= '0;
            hold  <= '0;
            p1vic <= only2;
            p2vic <= only1;
          end else if (tick) begin
            cnt <= '0;
            if (at_end) begin
              state <= POINT;
              hold  <= '0;
              p1vic <= ~recv_p1;
              p2vic <= recv_p1;
            end else begin
              ball_pos <= recv_p1 ? ball_pos + PW'(1) : ball_pos - PW'(1);
              ball_led <= recv_p1 ? ball_led << 1 : ball_led >> 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        POINT: begin
          if (tick) begin
            cnt <= '0;
            if (hold == HW'(HOLD_TICKS - 1)) begin
              // Loser serves next, ball parked at the loser's end.
              state     <= IDLE;
              p1vic     <= 1'b0;
              p2vic     <= 1'b0;
              server_p2 <= p1vic;
              ball_pos  <= p1vic ? END_P2 : END_P1;
              ball_led  <= onehot(p1vic ? END_P2 : END_P1);
            end else begin
              hold <= hold + HW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          ball_led <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_rodada.sv
// tb/tb_controle_rodada.sv - randomized scoreboard bench for the round referee
module tb_controle_rodada;

  localparam int WIDTH        = 8;
  localparam int TICK_DIV     = 8;
  localparam int HOLD_TICKS   = 2;
  localparam int SPEEDUP_HITS = 2;
  localparam int NCYC         = 20000;

  logic       clock = 1'b0;
  logic       reset, b1, b2, game_over;
  logic       p1vic, p2vic;
  logic [2:0] ball_pos;
  logic [7:0] ball_led;
  logic [2:0] state_o;

  controle_rodada #(
    .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS), .SPEEDUP_HITS(SPEEDUP_HITS)
  ) dut (
    .clock(clock), .reset(reset), .b1(b1), .b2(b2), .game_over(game_over),
    .p1vic(p1vic), .p2vic(p2vic), .ball_pos(ball_pos), .ball_led(ball_led), .state_o(state_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] pos;
    logic [7:0] led;
    logic       p1;
    logic       p2;
    logic [2:0] st;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Game-level reference: players numbered 1 and 2, winner 0 means no point pending.
  int m_pos, m_server, m_receiver, m_winner, m_level, m_hits, m_phase, m_holds;
  bit m_in_play, m_stopped;

  function automatic int end_of(input int player);
    return (player == 1) ? WIDTH - 1 : 0;
  endfunction

  task automatic model_step(input bit r, input bit p1, input bit p2, input bit go);
    bit only1, only2;
    only1 = p1 && !p2;
    only2 = p2 && !p1;
    if (!r) begin
      m_pos = WIDTH - 1; m_server = 1; m_receiver = 2; m_winner = 0;
      m_level = 0; m_hits = 0; m_phase = 0; m_holds = 0;
      m_in_play = 0; m_stopped = 0;
    end else if (go) begin
      m_stopped = 1;
    end else if (m_stopped) begin
      m_stopped = 1;
    end else if (m_winner != 0) begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_holds++;
        if (m_holds == HOLD_TICKS) begin
          m_server = 3 - m_winner;
          m_pos    = end_of(m_server);
          m_winner = 0;
        end
      end
    end else if (m_in_play) begin
      if (((m_receiver == 1 && only1) || (m_receiver == 2 && only2)) && m_pos == end_of(m_receiver)) begin
        m_receiver = 3 - m_receiver;
        m_hits++;
        if (m_hits % SPEEDUP_HITS == 0 && m_level < 3) m_level++;
        m_phase = 0;
      end else if (only1 || only2) begin
        m_winner = only1 ? 2 : 1;
        m_in_play = 0; m_phase = 0; m_holds = 0;
      end else begin
        m_phase++;
        if (m_phase == (TICK_DIV >> m_level)) begin
          m_phase = 0;
          if (m_pos == end_of(m_receiver)) begin
            m_winner = 3 - m_receiver;
            m_in_play = 0; m_holds = 0;
          end else begin
            m_pos += (m_receiver == 1) ? 1 : -1;
          end
        end
      end
    end else begin
      if ((m_server == 1 && only1) || (m_server == 2 && only2)) begin
        m_in_play = 1; m_receiver = 3 - m_server;
        m_level = 0; m_hits = 0; m_phase = 0;
      end
    end
  endtask

  function automatic snap_t model_out();
    snap_t s;
    s.pos = 3'(m_pos);
    s.led = m_stopped ? 8'h00 : 8'(1 << m_pos);
    s.p1  = !m_stopped && m_winner == 1;
    s.p2  = !m_stopped && m_winner == 2;
    if (m_stopped)        s.st = 3'd4;
    else if (m_winner != 0) s.st = 3'd3;
    else if (m_in_play)   s.st = (m_receiver == 1) ? 3'd1 : 3'd2;
    else                  s.st = 3'd0;
    return s;
  endfunction

  task automatic check(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after the edge.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        snap_t e;
        e = exp_q.pop_front();
        check("ball_pos", cyc, {5'd0, ball_pos}, {5'd0, e.pos});
        check("ball_led", cyc, ball_led, e.led);
        check("vic", cyc, {6'd0, p1vic, p2vic}, {6'd0, e.p1, e.p2});
        check("state", cyc, {5'd0, state_o}, {5'd0, e.st});
        cyc++;
      end
    end
  end

  // Driver: stimulus is chosen from the reference state so rallies actually happen.
  initial begin
    bit r, p1, p2, go;
    int stop_wait;
    stop_wait = 0;
    reset = 1'b0; b1 = 1'b0; b2 = 1'b0; game_over = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      r = 1; p1 = 0; p2 = 0; go = 0;
      if (c < 2) begin
        r = 0;
      end else if (m_stopped) begin
        stop_wait++;
        if (stop_wait > 12) begin
          r = 0;
          stop_wait = 0;
        end else begin
          p1 = ($urandom_range(0, 2) == 0);
          p2 = ($urandom_range(0, 2) == 0);
          go = ($urandom_range(0, 1) == 0);
        end
      end else if ($urandom_range(0, 2999) == 0) begin
        r = 0;
      end else if ($urandom_range(0, 1999) == 0) begin
        go = 1;
      end else if (m_winner != 0) begin
        p1 = ($urandom_range(0, 9) == 0);
        p2 = ($urandom_range(0, 9) == 0);
      end else if (m_in_play) begin
        if (m_pos == end_of(m_receiver) && $urandom_range(0, 3) == 0) begin
          if (m_receiver == 1) p1 = 1; else p2 = 1;
        end else if ($urandom_range(0, 149) == 0) begin
          p1 = 1;
        end else if ($urandom_range(0, 149) == 0) begin
          p2 = 1;
        end
        if ($urandom_range(0, 199) == 0) begin
          p1 = 1; p2 = 1;
        end
      end else begin
        if ($urandom_range(0, 5) == 0) begin
          if (m_server == 1) p1 = 1; else p2 = 1;
        end
        if ($urandom_range(0, 9) == 0) begin
          if (m_server == 1) p2 = 1; else p1 = 1;
        end
      end
      reset = r; b1 = p1; b2 = p2; game_over = go;
      model_step(r, p1, p2, go);
      exp_q.push_back(model_out());
    end
    @(negedge clock);
    b1 = 1'b0; b2 = 1'b0; game_over = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
